ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  Receive-only PS/2 device-to-host frame decoder for the on-board PS/2 port.
//  Synchronises and de-glitches PS2_CLK/PS2_DAT and samples data on filtered falling clock edges.
//  Checks start, odd parity and stop bits, then hands each scan-code byte to GameLogic over valid/ready.
//  Never drives the PS/2 lines; the top level keeps PS2_CLK/PS2_DAT at high-Z.
// PARAMETERS
//  FILTER_LEN      8      consecutive identical synced samples required to change filtered ps2 clock (>=2)
//  TIMEOUT_CYCLES  10000  clk cycles (200 us @ 50 MHz) without a falling edge mid-frame before abort
// PORTS
//  clk         in   1  system clock (CLOCK2_50 domain)
//  rst_n       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS2_CLK pin (asynchronous, idle high)
//  ps2_dat     in   1  raw PS2_DAT pin (asynchronous, idle high)
//  rx_data     out  8  received byte; stable while rx_valid=1
//  rx_valid    out  1  byte available; held until accepted
//  rx_ready    in   1  consumer accepts byte when rx_valid & rx_ready at posedge clk
//  parity_err  out  1  1-cycle pulse: frame had even parity, byte discarded
//  frame_err   out  1  1-cycle pulse: bad start/stop bit or timeout, frame discarded
//  overrun     out  1  1-cycle pulse: good byte completed while previous still unaccepted
//  busy        out  1  1 while the FSM is not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): rx_data=8'h00, rx_valid=0, all pulses=0, busy=0, FSM=IDLE,
//   sync FFs and filtered clk=1, filter count=0, bit count=0, timeout count=0.
//  Sync: 2-FF synchronisers on both pins. Filter: filt_clk takes the synced value only after
//   FILTER_LEN consecutive equal samples that differ from filt_clk. fall = filt_clk 1->0 (one-cycle strobe).
//  Data is sampled from the synced ps2_dat in the same cycle as fall.
//  FSM (advances only on fall, except timeout):
//   IDLE   : dat=0 -> DATA, bit count=0. dat=1 -> frame_err pulse, stay in IDLE.
//   DATA   : shift in LSB first (shreg <= {dat, shreg[7:1]}); after 8th bit -> PARITY.
//   PARITY : store bit -> STOP.
//   STOP   : always -> IDLE. Outcome in order of priority:
//            dat=0 -> frame_err; ^{shreg,par}=0 -> parity_err; else byte is good.
//  Timeout: timeout counter clears on every fall and in IDLE, counts otherwise.
//   At TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, partial byte discarded.
//  Delivery (good byte, evaluated in the cycle after the STOP fall):
//   rx_valid=0                -> rx_data<=byte, rx_valid<=1.
//   rx_valid=1 & rx_ready=1   -> old byte consumed, new byte loaded, rx_valid stays 1.
//   rx_valid=1 & rx_ready=0   -> overrun pulse; new byte dropped; rx_data/rx_valid unchanged.
//   Accept with no new byte   -> rx_valid<=0 next cycle; rx_data holds its last value.
//  Latency: rx_valid rises exactly 2 clk cycles after the cycle in which the STOP-bit fall strobe is high.
//  Error pulses rise in that same cycle; at most one of parity_err/frame_err/overrun is 1 per cycle.
//  Counter widths: $clog2(FILTER_LEN+1) and $clog2(TIMEOUT_CYCLES+1); counters saturate, never wrap.
//  busy=1 in DATA/PARITY/STOP.
//  rst_n low mid-frame: immediate abort to the reset state, no pulses.
//   After release, reception restarts with the next start bit. A partial frame already on the wire
//   may produce frame_err or a timeout.
// TESTING
//  Frame 0x1C (parity 0, stop 1), 12.5 kHz ps2 clock, rx_ready=1 -> one rx_valid cycle, rx_data=8'h1C, no errors.
//  Frame 0xF0 with parity 0 (even) -> parity_err one cycle, rx_valid stays 0, next good 0x1C delivered.
//  Frame 0x75 with stop bit 0 -> frame_err one cycle; 3 bits then clock held high 250 us -> frame_err, busy=0.
//  rx_ready=0, send 0x1D then 0x1B -> rx_data=8'h1D held, overrun pulse; rx_ready=1 -> rx_valid=0.
//  3-cycle glitch pulses on ps2_clk while idle -> no state change; rst_n low after bit 4 -> busy=0, outputs at reset values.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 device-to-host decoder: synchronise, de-glitch and frame-check PS/2 traffic,
// then hand each good scan-code byte to the consumer over a valid/ready handshake.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_clk_q, fall_q;
  logic [FW-1:0] filt_cnt_q;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          good_q, good_d, perr_pend_q, perr_d, ferr_pend_q, ferr_d;

  logic [7:0]    rx_data_q;
  logic          rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // filt_clk only follows the synced clock after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q != filt_clk_q) begin
        if (filt_cnt_q == FILT_LAST) begin
          filt_clk_q <= clk_s2_q;
          filt_cnt_q <= '0;
          fall_q     <= ~clk_s2_q;
        end else if (filt_cnt_q != FILT_MAX) begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      good_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      good_q      <= good_d;
      perr_pend_q <= perr_d;
      ferr_pend_q <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    good_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == IDLE || fall_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // a stalled frame is abandoned even if a fall lands in the same cycle
    if (state_q != IDLE && to_cnt_q == TO_LAST) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          if (bit_cnt_q == 4'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q} == 1'b0) begin
            perr_d = 1'b1;
          end else begin
            good_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // delivery stage: error pulses are delayed one cycle so they align with rx_valid rising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= perr_pend_q;
      frame_err_q  <= ferr_pend_q;
      overrun_q    <= 1'b0;
      if (good_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shreg_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: randomized PS/2 frames compared against a frame-level outcome model.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int H          = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       parity_err, frame_err, overrun, busy;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0, n_rise = 0, excl_viol = 0;
  int last_rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] acc_q[$];

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !prev_valid) begin
        n_rise++;
        last_rise_cyc = cyc;
      end
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (parity_err) n_perr++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if ((int'(parity_err) + int'(frame_err) + int'(overrun)) > 1) excl_viol++;
    end
    prev_valid = rx_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, output int fall_cyc);
    ps2_dat = b;
    wait_cyc(H);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            output int stop_fall);
    int fc;
    ps2_bit(1'b0, fc);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
    ps2_bit(par, fc);
    ps2_bit(stop, fc);
    stop_fall = fc;
    ps2_dat = 1'b1;
    wait_cyc(60);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic test_reset;
    wait_cyc(5);
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++;
    if ({parity_err, frame_err, overrun} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {parity_err, frame_err, overrun});
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    rst_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_basic;
    int sf, r0, a0, e0;
    rx_ready = 1'b1;
    r0 = n_rise; a0 = acc_q.size(); e0 = n_perr + n_ferr + n_ovr;
    send_frame(8'h1C, 1'b0, 1'b1, sf);
    if (n_rise - r0 !== 1) begin failures++; $display("FAIL basic_valid_rises got=%0d exp=1", n_rise - r0); end
    checks++;
    if (acc_q.size() - a0 !== 1) begin
      failures++; $display("FAIL basic_accepts got=%0d exp=1", acc_q.size() - a0);
    end else if (acc_q[a0] !== 8'h1C) begin
      failures++; $display("FAIL basic_data got=%h exp=1c", acc_q[a0]);
    end
    checks++;
    if (n_perr + n_ferr + n_ovr - e0 !== 0) begin
      failures++; $display("FAIL basic_errors got=%0d exp=0", n_perr + n_ferr + n_ovr - e0);
    end
    checks++;
    if (last_rise_cyc - sf < 11 || last_rise_cyc - sf > 13) begin
      failures++; $display("FAIL basic_latency got=%0d exp=11..13", last_rise_cyc - sf);
    end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", rx_valid); end
    checks++;
  endtask

  task automatic test_parity;
    int sf, p0, r0, a0;
    rx_ready = 1'b1;
    p0 = n_perr; r0 = n_rise;
    send_frame(8'hF0, 1'b0, 1'b1, sf);
    if (n_perr - p0 !== 1) begin failures++; $display("FAIL parity_pulse got=%0d exp=1", n_perr - p0); end
    checks++;
    if (n_rise - r0 !== 0) begin failures++; $display("FAIL parity_valid got=%0d exp=0", n_rise - r0); end
    checks++;
    a0 = acc_q.size();
    send_frame(8'h1C, 1'b0, 1'b1, sf);
    if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h1C) begin
      failures++; $display("FAIL parity_next_good got_n=%0d exp_n=1", acc_q.size() - a0);
    end
    checks++;
  endtask

  task automatic test_frame_err;
    int sf, f0, fc;
    f0 = n_ferr;
    send_frame(8'h75, 1'b0, 1'b0, sf);
    if (n_ferr - f0 !== 1) begin failures++; $display("FAIL stop_bit_ferr got=%0d exp=1", n_ferr - f0); end
    checks++;
    f0 = n_ferr;
    ps2_bit(1'b0, fc);
    ps2_bit(1'b1, fc);
    ps2_bit(1'b0, fc);
    wait_cyc(20);
    if (busy !== 1'b1) begin failures++; $display("FAIL partial_busy got=%b exp=1", busy); end
    checks++;
    ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 200);
    if (n_ferr - f0 !== 1) begin failures++; $display("FAIL timeout_ferr got=%0d exp=1", n_ferr - f0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++;
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int exp_p, exp_f, p0, f0, o0, a0, sf, kind;
    logic [7:0] b;
    rx_ready = 1'b1;
    exp_p = 0; exp_f = 0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr; a0 = acc_q.size();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        send_frame(b, ~odd_par(b), 1'b1, sf);
        exp_p++;
      end else if (kind == 1) begin
        send_frame(b, $urandom_range(0, 1) != 0, 1'b0, sf);
        exp_f++;
      end else begin
        send_frame(b, odd_par(b), 1'b1, sf);
        exp_q.push_back(b);
      end
    end
    if (n_perr - p0 !== exp_p) begin failures++; $display("FAIL rand_perr got=%0d exp=%0d", n_perr - p0, exp_p); end
    checks++;
    if (n_ferr - f0 !== exp_f) begin failures++; $display("FAIL rand_ferr got=%0d exp=%0d", n_ferr - f0, exp_f); end
    checks++;
    if (n_ovr - o0 !== 0) begin failures++; $display("FAIL rand_overrun got=%0d exp=0", n_ovr - o0); end
    checks++;
    if (acc_q.size() - a0 !== exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", acc_q.size() - a0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (acc_q[a0 + i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, acc_q[a0 + i], exp_q[i]);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_overrun;
    int sf, o0, a0;
    logic [7:0] b;
    rx_ready = 1'b0;
    o0 = n_ovr; a0 = acc_q.size();
    send_frame(8'h1D, odd_par(8'h1D), 1'b1, sf);
    if (rx_valid !== 1'b1 || rx_data !== 8'h1D) begin
      failures++; $display("FAIL ovr_first got=%b/%h exp=1/1d", rx_valid, rx_data);
    end
    checks++;
    send_frame(8'h1B, odd_par(8'h1B), 1'b1, sf);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, odd_par(b), 1'b1, sf);
    end
    if (n_ovr - o0 !== 4) begin failures++; $display("FAIL ovr_pulses got=%0d exp=4", n_ovr - o0); end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h1D) begin
      failures++; $display("FAIL ovr_held got=%b/%h exp=1/1d", rx_valid, rx_data);
    end
    checks++;
    rx_ready = 1'b1;
    wait_cyc(2);
    if (rx_valid !== 1'b0 || rx_data !== 8'h1D) begin
      failures++; $display("FAIL ovr_accept got=%b/%h exp=0/1d", rx_valid, rx_data);
    end
    checks++;
    if (acc_q.size() - a0 !== 1 || acc_q[a0] !== 8'h1D) begin
      failures++; $display("FAIL ovr_accepted_n got=%0d exp=1", acc_q.size() - a0);
    end
    checks++;
  endtask

  task automatic test_glitch;
    int e0, r0;
    logic saw_busy;
    e0 = n_perr + n_ferr + n_ovr; r0 = n_rise;
    saw_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      for (int k = 0; k < 20; k++) begin
        wait_cyc(1);
        if (busy) saw_busy = 1'b1;
      end
    end
    if (saw_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=1 exp=0"); end
    checks++;
    if (n_perr + n_ferr + n_ovr - e0 !== 0 || n_rise - r0 !== 0) begin
      failures++; $display("FAIL glitch_events got=%0d exp=0", n_perr + n_ferr + n_ovr - e0 + n_rise - r0);
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int sf, fc, f0, a0;
    rx_ready = 1'b0;
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, sf);
    ps2_bit(1'b0, fc);
    ps2_bit(1'b1, fc);
    ps2_bit(1'b1, fc);
    ps2_bit(1'b0, fc);
    wait_cyc(5);
    rst_n = 1'b0;
    ps2_dat = 1'b1;
    wait_cyc(3);
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      failures++; $display("FAIL rstmid_out got=%b/%h exp=0/00", rx_valid, rx_data);
    end
    checks++;
    if ({parity_err, frame_err, overrun} !== 3'b000) begin
      failures++; $display("FAIL rstmid_pulses got=%b exp=000", {parity_err, frame_err, overrun});
    end
    checks++;
    rst_n = 1'b1;
    f0 = n_ferr;
    wait_cyc(TIMEOUT + 100);
    rx_ready = 1'b1;
    a0 = acc_q.size();
    send_frame(8'h1C, 1'b0, 1'b1, sf);
    if (n_ferr - f0 !== 0) begin failures++; $display("FAIL rstmid_ferr got=%0d exp=0", n_ferr - f0); end
    checks++;
    if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h1C) begin
      failures++; $display("FAIL rstmid_recover got_n=%0d exp_n=1", acc_q.size() - a0);
    end
    checks++;
  endtask

  task automatic test_exclusive;
    if (excl_viol !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_viol); end
    checks++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_random;
    test_overrun;
    test_glitch;
    test_reset_mid;
    test_exclusive;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
